option_scheduler: RTL and testbench
===================================

Name: option_scheduler

Overview:
- Upstream feeder for the nonogram line solver. It holds every candidate line option in a circular buffer and streams the solver one word per cycle: a line-index word, then that line's options.
- Options the solver flags with put_back_to_FIFO are re-enqueued for the next round; all other options are dropped.
- It keeps per-line option counts, publishes them as old_options_amnt, and detects solved or stalled termination.

Parameters:
- SIZE, 3, maximum rows/cols; also the option word width.
- DEPTH, 64, buffer entries (power of two).
- CNT_W, 7, per-line count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- num_rows  in  4  rows in puzzle
- num_cols  in  4  cols in puzzle
- load_valid  in  1  loader word valid
- load_ready  out  1  buffer can accept load word
- load_word  in  SIZE  option bits, or line index when load_is_index=1
- load_is_index  in  1  word is a line index
- load_last  in  1  final load word
- option  out  SIZE  word to solver
- valid_op  out  1  option valid
- started  out  1  first word of first round
- old_options_amnt  out  [2*SIZE-1:0][CNT_W-1:0]  option counts per line (rows first, then cols)
- put_back_to_FIFO  in  1  solver keep-flag for the option issued last cycle
- solved  in  1  solver reports board complete
- done  out  1  solved termination
- stuck  out  1  round made no progress
- round_cnt  out  8  completed rounds

Behaviour:
- Reset values: all outputs 0; buffer pointers 0; counts 0; state IDLE.
- Entry format: {is_index, word}. Line index occupies the low bits of word, 0..2*SIZE-1.
- States:
  - IDLE: go to LOAD on the first load_valid.
  - LOAD: load_ready=!full. On each accepted word, push it. Index words set cur_line; option words increment cnt[cur_line]. On accepted load_last, snapshot occupancy into round_len and copy cnt into old_options_amnt, then go to RUN.
  - RUN: each cycle, pop one entry and drive option/valid_op=1. started=1 on the very first pop after LOAD only. After round_len pops, go to DRAIN.
  - DRAIN: one cycle with valid_op=0, waiting for the last put_back. Then evaluate:
    - new cnt equals old_options_amnt → STUCK.
    - otherwise copy cnt into old_options_amnt, round_cnt++, round_len = occupancy, return to RUN.
  - DONE and STUCK: terminal. valid_op=0; done or stuck held at 1 until reset.
- Feedback: put_back_to_FIFO is fixed at one-cycle latency. Each popped word is held in a pending register for one cycle. On the next cycle, pending is pushed if it is an index, or if it is an option and put_back_to_FIFO=1. That guarantees at most one push and one pop per cycle, and preserves index-before-options order.
- Counts: cnt[line] is cleared when that line's index is popped, then incremented per kept option. Indices are always re-pushed.
- solved=1 in any RUN/DRAIN cycle → DONE next cycle. The pending word is discarded.
- Full during RUN cannot occur: pop precedes push. Simultaneous push and pop in the same cycle leaves occupancy unchanged.
- A load word while full is not accepted; the loader holds it.
- Pointer wrap at DEPTH is natural modulo.
- round_cnt saturates at 255.
- Reset mid-operation (async) → IDLE; all state cleared, buffer contents ignored.
- Words with index ≥ num_rows+num_cols are a loader error; their options are counted to no line.

Decomposition:
- Package option_pkg: SIZE, CNT_W, entry struct {is_index, word}, state enum.
- Sub-module opt_ring (DEPTH×(SIZE+1) circular buffer with push, pop, occupancy count).

Test Plan:
- Load the 3×3 board (R1: 0,110,011; R2: 1,100,010,001; R3: 2,101; C1: 3,101; C2: 4,110,011; C3: 5,100,010,001; 18 words) → old_options_amnt={2,3,1,1,2,3}; started on first RUN word 000; 18 consecutive valid_op cycles.
- Round 1 put_back kept only R1 both, R2 all, C2 011, C3 100 → round 2 old_options_amnt={2,3,0,0,1,1}; 13 words issued; round_cnt=1.
- Round 2 identical put_back pattern → stuck=1, valid_op=0 thereafter.
- solved pulsed mid-round 2 → done=1 next cycle, no further valid_op.
- DEPTH=8 with 10 load words → load_ready low after 8 accepted; loader stalls. Solver keeps all → wrap-around order preserved.
- rst_n asserted mid-RUN → all outputs 0 immediately; a reload produces correct round-1 counts.

Source files
------------

// File: rtl/option_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// option_pkg
// Shared types and constants for the nonogram option scheduler:
//   SIZE       board dimension limit and option word width
//   CNT_W      width of one per-line option count
//   NUM_LINES  rows + cols slots in the count vector (rows first, then cols)
//   entry_t    one buffer entry {is_index, word}
//   state_t    scheduler FSM states
//   cnt_vec_t  packed per-line count vector, element [line] belongs to line
// -----------------------------------------------------------------------------
package option_pkg;

    localparam int SIZE      = 3;
    localparam int CNT_W     = 7;
    localparam int NUM_LINES = 2 * SIZE;

    typedef struct packed {
        logic            is_index;
        logic [SIZE-1:0] word;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_STUCK
    } state_t;

    typedef logic [NUM_LINES-1:0][CNT_W-1:0] cnt_vec_t;

    // A line index is usable only if it names a line of this puzzle and fits
    // the count vector; options that follow an unusable index count nowhere.
    function automatic logic line_in_range(input logic [SIZE-1:0] idx,
                                           input logic [3:0]      rows,
                                           input logic [3:0]      cols);
        return (int'(idx) < int'(rows) + int'(cols)) && (int'(idx) < NUM_LINES);
    endfunction

endpackage

// File: rtl/option_scheduler_ring.sv
// -----------------------------------------------------------------------------
// opt_ring
// DEPTH-entry circular buffer of entry_t with one push and one pop per cycle.
// The head entry is readable combinationally so the scheduler can issue it in
// the same cycle it pops it.
//   clk, rst_n   clock, asynchronous active-low reset (clears pointers only)
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          advance the head
//   head         entry currently at the head (undefined when empty)
//   count        occupancy, 0..DEPTH
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module opt_ring
    import option_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // NOTE: storage has no reset; entries are only read after being written,
    // so clearing the pointers is enough and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: every output of this block gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so DEPTH wrap is plain overflow.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/option_scheduler.sv
// -----------------------------------------------------------------------------
// option_scheduler
// Feeds the nonogram line solver from a circular buffer of {is_index, word}
// entries: each round streams every stored entry once (line index, then that
// line's options), re-queues indices and the options the solver keeps, and
// compares per-line counts between rounds to detect a stall.
//   num_rows/num_cols        puzzle dimensions (bound the valid line indices)
//   load_valid/ready/word/is_index/last   loader handshake and payload
//   option, valid_op         word issued to the solver this cycle
//   started                  high with the first word of the first round
//   old_options_amnt         per-line counts of the round now running
//   put_back_to_FIFO         keep-flag for the word issued the previous cycle
//   solved                   solver reports the board complete
//   done, stuck              terminal flags, held until reset
//   round_cnt                completed rounds, saturating at 255
// -----------------------------------------------------------------------------
module option_scheduler
    import option_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [3:0]                       num_rows,
    input  logic [3:0]                       num_cols,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [SIZE-1:0]                  load_word,
    input  logic                             load_is_index,
    input  logic                             load_last,
    output logic [SIZE-1:0]                  option,
    output logic                             valid_op,
    output logic                             started,
    output logic [2*SIZE-1:0][CNT_W-1:0]     old_options_amnt,
    input  logic                             put_back_to_FIFO,
    input  logic                             solved,
    output logic                             done,
    output logic                             stuck,
    output logic [7:0]                       round_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_t         state_q, state_d;
    cnt_vec_t       cnt_q, cnt_d;
    cnt_vec_t       old_q, old_d;
    logic [SIZE-1:0] cur_line_q, cur_line_d;
    logic           line_ok_q, line_ok_d;
    entry_t         pend_q, pend_d;
    logic           pend_v_q, pend_v_d;
    logic [AW:0]    round_len_q, round_len_d;
    logic [AW:0]    pop_cnt_q, pop_cnt_d;
    logic           first_q, first_d;
    logic [7:0]     round_cnt_q, round_cnt_d;

    entry_t         ring_head, ring_push_data, load_entry;
    logic           ring_push, ring_pop, ring_full, ring_empty;
    logic [AW:0]    ring_count;

    logic           load_accept, active, retire_index, retire_keep, progress;
    logic [AW:0]    pop_cnt_inc;

    opt_ring #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ring_push),
        .push_data (ring_push_data),
        .pop       (ring_pop),
        .head      (ring_head),
        .count     (ring_count),
        .full      (ring_full),
        .empty     (ring_empty)
    );

    assign load_entry   = '{is_index: load_is_index, word: load_word};
    assign load_accept  = (state_q == S_LOAD) && load_valid && !ring_full;
    // A solved pulse freezes the buffer: no pop, and the pending word is dropped.
    assign active       = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !solved;
    // The word popped last cycle retires now, once its keep-flag is known.
    // Indices always go back so every line keeps its header for later rounds.
    assign retire_index = active && pend_v_q && pend_q.is_index;
    assign retire_keep  = active && pend_v_q && !pend_q.is_index && put_back_to_FIFO;
    assign ring_pop     = active && (state_q == S_RUN) && !ring_empty;
    assign ring_push    = load_accept || retire_index || retire_keep;
    assign ring_push_data = load_accept ? load_entry : pend_q;
    assign pop_cnt_inc  = pop_cnt_q + 1'b1;

    // Per-line counts follow the retire stage, so the line pointer always
    // belongs to the pending word rather than the word being popped.
    always_comb begin
        cnt_d      = cnt_q;
        cur_line_d = cur_line_q;
        line_ok_d  = line_ok_q;
        if (load_accept) begin
            if (load_is_index) begin
                cur_line_d = load_word;
                line_ok_d  = line_in_range(load_word, num_rows, num_cols);
            end else if (line_ok_q) begin
                cnt_d[cur_line_q] = cnt_q[cur_line_q] + 1'b1;
            end
        end else if (retire_index) begin
            cur_line_d = pend_q.word;
            line_ok_d  = line_in_range(pend_q.word, num_rows, num_cols);
            if (line_ok_d) cnt_d[pend_q.word] = '0;
        end else if (retire_keep && line_ok_q) begin
            cnt_d[cur_line_q] = cnt_q[cur_line_q] + 1'b1;
        end
    end

    // Includes the last keep-flag of the round, which arrives during DRAIN.
    assign progress = (cnt_d != old_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (load_valid) state_d = S_LOAD;
            S_LOAD:  if (load_accept && load_last) state_d = S_RUN;
            S_RUN: begin
                if (solved) begin
                    state_d = S_DONE;
                end else if (ring_empty || (pop_cnt_inc == round_len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (solved)         state_d = S_DONE;
                else if (!progress) state_d = S_STUCK;
                else                state_d = S_RUN;
            end
            S_DONE, S_STUCK: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
    end

    // Round bookkeeping and the pending stage.
    always_comb begin
        pend_d      = pend_q;
        pend_v_d    = 1'b0;
        pop_cnt_d   = pop_cnt_q;
        round_len_d = round_len_q;
        old_d       = old_q;
        round_cnt_d = round_cnt_q;
        first_d     = first_q;
        if (load_accept && load_last) begin
            // No pop happens during LOAD, so occupancy after this push is +1.
            round_len_d = ring_count + 1'b1;
            old_d       = cnt_d;
            pop_cnt_d   = '0;
            first_d     = 1'b1;
        end
        if (ring_pop) begin
            pend_d    = ring_head;
            pend_v_d  = 1'b1;
            pop_cnt_d = pop_cnt_inc;
            first_d   = 1'b0;
        end
        if (active && (state_q == S_DRAIN) && progress) begin
            old_d       = cnt_d;
            round_len_d = ring_count + (AW+1)'(ring_push);
            pop_cnt_d   = '0;
            if (round_cnt_q != 8'hFF) round_cnt_d = round_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            old_q       <= '0;
            cur_line_q  <= '0;
            line_ok_q   <= 1'b0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            round_len_q <= '0;
            pop_cnt_q   <= '0;
            first_q     <= 1'b0;
            round_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            old_q       <= old_d;
            cur_line_q  <= cur_line_d;
            line_ok_q   <= line_ok_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            round_len_q <= round_len_d;
            pop_cnt_q   <= pop_cnt_d;
            first_q     <= first_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Outputs decode from state only, so they read 0 right after reset.
    always_comb begin
        load_ready = 1'b0;
        valid_op   = 1'b0;
        option     = '0;
        started    = 1'b0;
        done       = 1'b0;
        stuck      = 1'b0;
        unique case (state_q)
            S_LOAD:  load_ready = !ring_full;
            S_RUN: begin
                if (!ring_empty) begin
                    valid_op = 1'b1;
                    option   = ring_head.word;
                    started  = first_q;
                end
            end
            S_DONE:  done  = 1'b1;
            S_STUCK: stuck = 1'b1;
            default: ;
        endcase
    end

    assign old_options_amnt = old_q;
    assign round_cnt        = round_cnt_q;

endmodule

// File: tb/tb_option_scheduler.sv
// -----------------------------------------------------------------------------
// tb_option_scheduler
// Directed bench for option_scheduler: a DEPTH=64 instance runs the 3x3 board
// (stall detection, mid-run reset, solved termination) and a DEPTH=8 instance
// covers loader back-pressure and pointer wrap.
// -----------------------------------------------------------------------------
module tb_option_scheduler;
    import option_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] num_rows, num_cols;
    logic load_valid, load_is_index, load_last;
    logic [SIZE-1:0] load_word;
    logic put_back_to_FIFO, solved;
    logic use_b;

    logic load_ready_a, valid_op_a, started_a, done_a, stuck_a;
    logic load_ready_b, valid_op_b, started_b, done_b, stuck_b;
    logic [SIZE-1:0] option_a, option_b;
    cnt_vec_t old_a, old_b;
    logic [7:0] round_cnt_a, round_cnt_b;

    logic load_ready_m, valid_op_m, started_m, done_m, stuck_m;
    logic [SIZE-1:0] option_m;
    cnt_vec_t old_m;
    logic [7:0] round_cnt_m;

    int total = 0;
    int bad   = 0;
    logic pb_next = 1'b0;

    logic [2:0] cur_w [32];
    logic       cur_k [32];

    // 3x3 board: load stream and round-1 issue order are the same sequence.
    logic [2:0] board_w [18] = '{0,6,3, 1,4,2,1, 2,5, 3,5, 4,6,3, 5,4,2,1};
    logic       board_i [18] = '{1,0,0, 1,0,0,0, 1,0, 1,0, 1,0,0, 1,0,0,0};
    logic       r1_k    [18] = '{0,1,1, 0,1,1,1, 0,0, 0,0, 0,0,1, 0,1,0,0};
    logic [2:0] r2_w    [13] = '{0,6,3, 1,4,2,1, 2, 3, 4,3, 5,4};
    logic       r2_k    [13] = '{0,1,1, 0,1,1,1, 0, 0, 0,1, 0,1};
    // DEPTH=8 instance.
    logic [2:0] b_w     [10] = '{0,6,3, 1,4,2,1, 2, 5, 3};
    logic       b_i     [10] = '{1,0,0, 1,0,0,0, 1, 0, 1};
    logic       b1_k    [8]  = '{0,0,1, 0,1,1,1, 0};
    logic [2:0] b2_w    [7]  = '{0,3, 1,4,2,1, 2};
    logic       b2_k    [7]  = '{0,1, 0,1,1,1, 0};

    always #5 clk = ~clk;

    option_scheduler u_a (
        .clk(clk), .rst_n(rst_n), .num_rows(num_rows), .num_cols(num_cols),
        .load_valid(load_valid), .load_ready(load_ready_a), .load_word(load_word),
        .load_is_index(load_is_index), .load_last(load_last),
        .option(option_a), .valid_op(valid_op_a), .started(started_a),
        .old_options_amnt(old_a), .put_back_to_FIFO(put_back_to_FIFO),
        .solved(solved), .done(done_a), .stuck(stuck_a), .round_cnt(round_cnt_a)
    );

    option_scheduler #(.DEPTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .num_rows(num_rows), .num_cols(num_cols),
        .load_valid(load_valid), .load_ready(load_ready_b), .load_word(load_word),
        .load_is_index(load_is_index), .load_last(load_last),
        .option(option_b), .valid_op(valid_op_b), .started(started_b),
        .old_options_amnt(old_b), .put_back_to_FIFO(put_back_to_FIFO),
        .solved(solved), .done(done_b), .stuck(stuck_b), .round_cnt(round_cnt_b)
    );

    assign load_ready_m = use_b ? load_ready_b : load_ready_a;
    assign valid_op_m   = use_b ? valid_op_b   : valid_op_a;
    assign started_m    = use_b ? started_b    : started_a;
    assign done_m       = use_b ? done_b       : done_a;
    assign stuck_m      = use_b ? stuck_b      : stuck_a;
    assign option_m     = use_b ? option_b     : option_a;
    assign old_m        = use_b ? old_b        : old_a;
    assign round_cnt_m  = use_b ? round_cnt_b  : round_cnt_a;

    function automatic cnt_vec_t mk_cnt(input int c0, input int c1, input int c2,
                                        input int c3, input int c4, input int c5);
        cnt_vec_t v;
        v[0] = CNT_W'(c0); v[1] = CNT_W'(c1); v[2] = CNT_W'(c2);
        v[3] = CNT_W'(c3); v[4] = CNT_W'(c4); v[5] = CNT_W'(c5);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; the keep-flag chosen for last cycle's word
    // becomes visible to the DUT for the whole following cycle.
    task automatic tick();
        @(negedge clk);
        put_back_to_FIFO = pb_next;
        pb_next = 1'b0;
    endtask

    task automatic send(input logic [2:0] w, input logic is_idx, input logic last);
        int n = 0;
        load_valid = 1'b1; load_word = w; load_is_index = is_idx; load_last = last;
        while (load_ready_m !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("load_ready", 64'(load_ready_m), 64'(1'b1));
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_load_ready"}, 64'(load_ready_m), 64'(0));
        check({tag, "_valid_op"},   64'(valid_op_m),   64'(0));
        check({tag, "_option"},     64'(option_m),     64'(0));
        check({tag, "_started"},    64'(started_m),    64'(0));
        check({tag, "_done"},       64'(done_m),       64'(0));
        check({tag, "_stuck"},      64'(stuck_m),      64'(0));
        check({tag, "_round_cnt"},  64'(round_cnt_m),  64'(0));
        check({tag, "_counts"},     64'(old_m),        64'(0));
    endtask

    task automatic run_round(input string tag, input int n, input logic first,
                             input cnt_vec_t exp_cnt, input logic [7:0] exp_rc,
                             input int solve_at);
        int w = 0;
        while (valid_op_m !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_start"},     64'(valid_op_m),  64'(1'b1));
        check({tag, "_counts"},    64'(old_m),       64'(exp_cnt));
        check({tag, "_round_cnt"}, 64'(round_cnt_m), 64'(exp_rc));
        for (int i = 0; i < n; i++) begin
            if (i == solve_at) begin
                solved = 1'b1;
                tick();
                solved = 1'b0;
                check({tag, "_solved_done"},  64'(done_m),     64'(1'b1));
                check({tag, "_solved_valid"}, 64'(valid_op_m), 64'(1'b0));
                return;
            end
            check($sformatf("%s_valid[%0d]", tag, i), 64'(valid_op_m), 64'(1'b1));
            check($sformatf("%s_word[%0d]", tag, i),  64'(option_m),   64'(cur_w[i]));
            if (i < 2) check($sformatf("%s_started[%0d]", tag, i), 64'(started_m),
                             64'(first && (i == 0)));
            pb_next = cur_k[i];
            tick();
        end
        check({tag, "_drain_idle"}, 64'(valid_op_m), 64'(1'b0));
    endtask

    task automatic load_board();
        for (int i = 0; i < 18; i++) send(board_w[i], board_i[i], i == 17);
    endtask

    task automatic set_r1();
        for (int i = 0; i < 18; i++) begin cur_w[i] = board_w[i]; cur_k[i] = r1_k[i]; end
    endtask

    task automatic set_r2();
        for (int i = 0; i < 13; i++) begin cur_w[i] = r2_w[i]; cur_k[i] = r2_k[i]; end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; use_b = 1'b0;
        num_rows = 4'd3; num_cols = 4'd3;
        load_valid = 1'b0; load_word = '0; load_is_index = 1'b0; load_last = 1'b0;
        put_back_to_FIFO = 1'b0; solved = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_load_ready", 64'(load_ready_m), 64'(0));

        // Board load, a progressing round, then an identical round -> stuck.
        load_board();
        set_r1();
        run_round("a_r1", 18, 1'b1, mk_cnt(2,3,1,1,2,3), 8'd0, -1);
        set_r2();
        run_round("a_r2", 13, 1'b0, mk_cnt(2,3,0,0,1,1), 8'd1, -1);
        tick();
        check("a_stuck",      64'(stuck_m),     64'(1));
        check("a_stuck_done", 64'(done_m),      64'(0));
        check("a_stuck_rc",   64'(round_cnt_m), 64'(1));
        repeat (3) begin
            tick();
            check("a_stuck_valid", 64'(valid_op_m), 64'(0));
            check("a_stuck_hold",  64'(stuck_m),    64'(1));
        end

        // Asynchronous reset in the middle of round 1.
        pulse_reset();
        load_board();
        repeat (4) tick();
        check("midrun_valid_before", 64'(valid_op_m), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_zero("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reload gives fresh round-1 counts; solved mid-round 2 ends in DONE.
        load_board();
        set_r1();
        run_round("b_r1", 18, 1'b1, mk_cnt(2,3,1,1,2,3), 8'd0, -1);
        set_r2();
        run_round("b_r2", 13, 1'b0, mk_cnt(2,3,0,0,1,1), 8'd1, 5);
        repeat (3) begin
            tick();
            check("done_valid", 64'(valid_op_m), 64'(0));
            check("done_hold",  64'(done_m),     64'(1));
            check("done_stuck", 64'(stuck_m),    64'(0));
        end

        // DEPTH=8: back-pressure after 8 accepted words.
        use_b = 1'b1;
        num_cols = 4'd0;
        pulse_reset();
        for (int i = 0; i < 8; i++) send(b_w[i], b_i[i], 1'b0);
        load_valid = 1'b1; load_word = b_w[8]; load_is_index = b_i[8]; load_last = 1'b0;
        repeat (4) begin
            check("full_load_ready", 64'(load_ready_m), 64'(0));
            tick();
        end
        load_valid = 1'b0;

        // DEPTH=8: full buffer at round start, write pointer wraps into round 2.
        pulse_reset();
        for (int i = 0; i < 8; i++) send(b_w[i], b_i[i], i == 7);
        for (int i = 0; i < 8; i++) begin cur_w[i] = b_w[i]; cur_k[i] = b1_k[i]; end
        run_round("w_r1", 8, 1'b1, mk_cnt(2,3,0,0,0,0), 8'd0, -1);
        for (int i = 0; i < 7; i++) begin cur_w[i] = b2_w[i]; cur_k[i] = b2_k[i]; end
        run_round("w_r2", 7, 1'b0, mk_cnt(1,3,0,0,0,0), 8'd1, -1);
        tick();
        check("w_stuck",    64'(stuck_m),     64'(1));
        check("w_stuck_rc", 64'(round_cnt_m), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
